// File: rtl/one_cycle_cpu_if.sv
// Host/debug bus of the single-cycle CPU: program load port plus debug views.
interface one_cycle_cpu_if;
   logic [15:0] data_in;
   logic [7:0]  inst_add;
   logic        isntruction_wenable;
   logic [1:0]  reg_address;
   logic        btnLEDS;
   logic [2:0]  Flags;
   logic [7:0]  registro;
   logic [7:0]  LEDS;
   logic        ledsito;

   modport master (
      output data_in, inst_add, isntruction_wenable, reg_address, btnLEDS,
      input  Flags, registro, LEDS, ledsito
   );

   modport slave (
      input  data_in, inst_add, isntruction_wenable, reg_address, btnLEDS,
      output Flags, registro, LEDS, ledsito
   );
endinterface

// File: rtl/one_cycle_cpu.sv
// Single-cycle 8-bit CPU: host-loaded 256x16 instruction memory, 4x8 register
// file, registered N/C/Z flags, one instruction retired per clock.
module one_cycle_cpu (
   input logic          clk,
   input logic          boton,
   one_cycle_cpu_if.slave bus
);
   localparam int unsigned DW         = 8;
   localparam int unsigned IW         = 16;
   localparam int unsigned AW         = 8;
   localparam int unsigned IMEM_DEPTH = 256;
   localparam int unsigned NREGS      = 4;
   localparam int unsigned RW         = 2;
   localparam int unsigned OPW        = 5;

   localparam logic [OPW-1:0] OP_ADD  = 5'b00001;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00010;
   localparam logic [OPW-1:0] OP_AND  = 5'b00011;
   localparam logic [OPW-1:0] OP_OR   = 5'b00100;
   localparam logic [OPW-1:0] OP_XOR  = 5'b00101;
   localparam logic [OPW-1:0] OP_NOT  = 5'b00110;
   localparam logic [OPW-1:0] OP_MOVI = 5'b01001;
   localparam logic [OPW-1:0] OP_ADDI = 5'b01010;
   localparam logic [OPW-1:0] OP_JMP  = 5'b01100;
   localparam logic [OPW-1:0] OP_JZ   = 5'b01101;
   localparam logic [OPW-1:0] OP_JC   = 5'b01110;
   localparam logic [OPW-1:0] OP_HALT = 5'b11111;

   logic [IW-1:0]  imem_q [IMEM_DEPTH];
   logic [DW-1:0]  regs_q [NREGS];
   logic [AW-1:0]  pc_q, pc_d;
   logic           n_q, n_d, c_q, c_d, z_q, z_d;
   logic           halted_q, halted_d;

   logic [IW-1:0]  instr;
   logic [OPW-1:0] op;
   logic [RW-1:0]  rd, rs1, rs2;
   logic [DW-1:0]  imm, opa, opb, opd;
   logic [DW-1:0]  result;
   logic           alu_c;
   logic           wb_en;
   logic           flag_en;

   // Program memory is never reset so a program survives a core reset.
   always_ff @(posedge clk) begin
      if (bus.isntruction_wenable) begin
         imem_q[bus.inst_add] <= bus.data_in;
      end
   end

   always_comb begin
      instr = imem_q[pc_q];
      op    = instr[15:11];
      rd    = instr[10:9];
      rs1   = instr[8:7];
      rs2   = instr[6:5];
      imm   = instr[7:0];
      opa   = regs_q[rs1];
      opb   = regs_q[rs2];
      opd   = regs_q[rd];
   end

   // Decode/execute: next PC, write-back value and flag update for this cycle.
   always_comb begin
      pc_d     = pc_q + AW'(1);
      halted_d = halted_q;
      result   = '0;
      alu_c    = 1'b0;
      wb_en    = 1'b0;
      flag_en  = 1'b0;

      if (bus.isntruction_wenable) begin
         pc_d     = '0;
         halted_d = 1'b0;
      end else if (halted_q) begin
         pc_d = pc_q;
      end else begin
         case (op)
            OP_ADD: begin
               {alu_c, result} = {1'b0, opa} + {1'b0, opb};
               wb_en   = 1'b1;
               flag_en = 1'b1;
            end
            OP_SUB: begin
               result  = opa - opb;
               alu_c   = (opa < opb);
               wb_en   = 1'b1;
               flag_en = 1'b1;
            end
            OP_AND: begin
               result  = opa & opb;
               wb_en   = 1'b1;
               flag_en = 1'b1;
            end
            OP_OR: begin
               result  = opa | opb;
               wb_en   = 1'b1;
               flag_en = 1'b1;
            end
            OP_XOR: begin
               result  = opa ^ opb;
               wb_en   = 1'b1;
               flag_en = 1'b1;
            end
            OP_NOT: begin
               result  = ~opa;
               wb_en   = 1'b1;
               flag_en = 1'b1;
            end
            OP_MOVI: begin
               result = imm;
               wb_en  = 1'b1;
            end
            OP_ADDI: begin
               {alu_c, result} = {1'b0, opd} + {1'b0, imm};
               wb_en   = 1'b1;
               flag_en = 1'b1;
            end
            OP_JMP: pc_d = imm;
            OP_JZ:  if (z_q) pc_d = imm;
            OP_JC:  if (c_q) pc_d = imm;
            OP_HALT: begin
               pc_d     = pc_q;
               halted_d = 1'b1;
            end
            default: ;
         endcase
      end

      n_d = flag_en ? result[DW-1]       : n_q;
      c_d = flag_en ? alu_c              : c_q;
      z_d = flag_en ? (result == DW'(0)) : z_q;
   end

   always_ff @(posedge clk or posedge boton) begin
      if (boton) begin
         pc_q     <= '0;
         n_q      <= 1'b0;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         halted_q <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         pc_q     <= pc_d;
         n_q      <= n_d;
         c_q      <= c_d;
         z_q      <= z_d;
         halted_q <= halted_d;
         if (wb_en) begin
            regs_q[rd] <= result;
         end
      end
   end

   // Debug views are combinational so the host sees state without latency.
   assign bus.Flags    = {n_q, c_q, z_q};
   assign bus.registro = regs_q[bus.reg_address];
   assign bus.LEDS     = bus.btnLEDS ? bus.registro : pc_q;
   assign bus.ledsito  = ~boton & ~bus.isntruction_wenable & ~halted_q;

endmodule

// File: tb/tb_one_cycle_cpu.sv
// Directed bench for one_cycle_cpu: load programs, run, and compare debug views.
module tb_one_cycle_cpu;
   logic clk;
   logic boton;
   int   n_checks;
   int   n_pass;

   one_cycle_cpu_if bus ();

   one_cycle_cpu dut (
      .clk   (clk),
      .boton (boton),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic chk_reg(input string tag, input int idx, input logic [7:0] exp);
      bus.reg_address = 2'(idx);
      #1;
      check(tag, 16'(bus.registro), 16'(exp));
   endtask

   task automatic load(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.isntruction_wenable = 1'b1;
      bus.inst_add            = a;
      bus.data_in             = d;
   endtask

   task automatic release_core();
      @(negedge clk);
      bus.isntruction_wenable = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      boton                   = 1'b1;
      bus.isntruction_wenable = 1'b1;
      bus.data_in             = '0;
      bus.inst_add            = '0;
      bus.reg_address         = '0;
      bus.btnLEDS             = 1'b0;

      // Reset state
      @(negedge clk);
      #1;
      check("rst_flags", 16'(bus.Flags), 16'h0);
      check("rst_pc", 16'(bus.LEDS), 16'h00);
      check("rst_ledsito", 16'(bus.ledsito), 16'h0);
      chk_reg("rst_r0", 0, 8'h00);
      boton = 1'b0;

      // Basic MOVI/ADD program
      load(8'd0, 16'h4810);
      load(8'd1, 16'h4A12);
      load(8'd2, 16'h4C14);
      load(8'd3, 16'h4E16);
      load(8'd4, 16'h0880);
      load(8'd5, 16'hF800);
      release_core();
      #1;
      check("run_pc0", 16'(bus.LEDS), 16'h00);
      check("run_ledsito", 16'(bus.ledsito), 16'h1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("pc_count%0d", k), 16'(bus.LEDS), 16'(k));
      end
      @(negedge clk);
      chk_reg("p1_r0", 0, 8'h22);
      chk_reg("p1_r1", 1, 8'h12);
      chk_reg("p1_r2", 2, 8'h14);
      chk_reg("p1_r3", 3, 8'h16);
      @(negedge clk);
      #1;
      check("p1_flags", 16'(bus.Flags), 16'h0);
      check("p1_halt_pc", 16'(bus.LEDS), 16'h05);
      check("p1_halt_led", 16'(bus.ledsito), 16'h0);
      bus.btnLEDS = 1'b1;
      chk_reg("p1_leds_reg", 0, 8'h22);
      check("p1_leds_view", 16'(bus.LEDS), 16'h22);

      // Flags and control-flow program; also checks programming hold
      bus.btnLEDS = 1'b0;
      load(8'd0, 16'h4AFF);
      load(8'd1, 16'h4C01);
      #1;
      check("hold_pc", 16'(bus.LEDS), 16'h00);
      check("hold_ledsito", 16'(bus.ledsito), 16'h0);
      chk_reg("hold_r0", 0, 8'h22);
      load(8'd2, 16'h08C0);
      load(8'd3, 16'h1120);
      load(8'd4, 16'h6810);
      load(8'd5, 16'h17E0);
      load(8'd6, 16'h6810);
      load(8'd7, 16'hF800);
      load(8'h10, 16'hF800);
      #1;
      check("hold_r0_late", 16'(bus.registro), 16'h22);
      release_core();
      @(negedge clk);
      chk_reg("movi_r1", 1, 8'hFF);
      @(negedge clk);
      chk_reg("movi_r2", 2, 8'h01);
      @(negedge clk);
      chk_reg("add_r0", 0, 8'h00);
      check("add_flags", 16'(bus.Flags), 16'h3);
      @(negedge clk);
      chk_reg("sub_r0", 0, 8'h02);
      check("sub_flags", 16'(bus.Flags), 16'h2);
      @(negedge clk);
      #1;
      check("jz_not_taken", 16'(bus.LEDS), 16'h05);
      @(negedge clk);
      chk_reg("sub_r3", 3, 8'h00);
      check("sub_z_flags", 16'(bus.Flags), 16'h1);
      @(negedge clk);
      #1;
      check("jz_taken", 16'(bus.LEDS), 16'h10);
      @(negedge clk);
      #1;
      check("halt_pc", 16'(bus.LEDS), 16'h10);
      check("halt_ledsito", 16'(bus.ledsito), 16'h0);
      @(negedge clk);
      #1;
      check("halt_pc_hold", 16'(bus.LEDS), 16'h10);

      // Asynchronous reset mid-cycle, then re-execution from intact memory
      @(negedge clk);
      #2;
      boton = 1'b1;
      #1;
      check("arst_flags", 16'(bus.Flags), 16'h0);
      check("arst_pc", 16'(bus.LEDS), 16'h00);
      chk_reg("arst_r1", 1, 8'h00);
      @(negedge clk);
      boton = 1'b0;
      #1;
      check("rerun_ledsito", 16'(bus.ledsito), 16'h1);
      repeat (3) @(negedge clk);
      chk_reg("rerun_r1", 1, 8'hFF);
      chk_reg("rerun_r0", 0, 8'h00);
      check("rerun_flags", 16'(bus.Flags), 16'h3);
      @(negedge clk);
      chk_reg("rerun_r0b", 0, 8'h02);
      check("rerun_flags2", 16'(bus.Flags), 16'h2);

      // PC wrap over an all-NOP program
      for (int a = 0; a < 256; a++) begin
         load(8'(a), 16'h0000);
      end
      release_core();
      repeat (255) @(negedge clk);
      #1;
      check("wrap_pc_ff", 16'(bus.LEDS), 16'hFF);
      @(negedge clk);
      #1;
      check("wrap_pc_00", 16'(bus.LEDS), 16'h00);
      chk_reg("wrap_r0", 0, 8'h02);
      chk_reg("wrap_r1", 1, 8'hFF);
      check("wrap_flags", 16'(bus.Flags), 16'h2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
